// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bus between the fetch/commit sequencer and the KGP-RISC datapath/control unit.
//
// Signals:
//   run            start request (sampled by the sequencer only while idle)
//   opcode         instr[31:27] from the datapath
//   nextInstrAddr  next PC computed by the datapath
//   memRead        control-unit memory-read flag for the current instruction
//   regWriteIn     control-unit register write request (ungated)
//   memWriteIn     control-unit memory write request (ungated)
//   instrAddr      PC driven to the instruction memory
//   regWrite       gated register write enable
//   memWrite       gated memory write enable
//   commit         one-cycle retirement strobe
//   halted         machine stopped on the halt opcode
//   instrCount     retired instruction count
//   cycleCount     active cycle count
//
// Modports: master = sequencer side, slave = datapath/control side.
// -----------------------------------------------------------------------------
interface pc_sequencer_if;
    logic        run;
    logic [4:0]  opcode;
    logic [31:0] nextInstrAddr;
    logic        memRead;
    logic        regWriteIn;
    logic        memWriteIn;
    logic [31:0] instrAddr;
    logic        regWrite;
    logic        memWrite;
    logic        commit;
    logic        halted;
    logic [31:0] instrCount;
    logic [31:0] cycleCount;

    modport master (
        input  run, opcode, nextInstrAddr, memRead, regWriteIn, memWriteIn,
        output instrAddr, regWrite, memWrite, commit, halted, instrCount, cycleCount
    );

    modport slave (
        output run, opcode, nextInstrAddr, memRead, regWriteIn, memWriteIn,
        input  instrAddr, regWrite, memWrite, commit, halted, instrCount, cycleCount
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle fetch/commit sequencer sitting directly upstream of the KGP-RISC
// datapath. Owns the PC, steps each instruction through FETCH, EXEC, an
// optional data-memory wait and COMMIT, and gates the control unit's write
// enables so architectural state only changes in the commit cycle. Stops on
// the halt opcode and keeps saturating retired-instruction / active-cycle
// counters.
//
// Ports:
//   clk  system clock, all state updates on posedge
//   rst  synchronous, active-high reset (priority over everything)
//   bus  pc_sequencer_if.master (control inputs in, PC/enables/counters out)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [4:0]  HALT_OPCODE = 5'b11111,
    parameter int unsigned MEM_WAIT    = 1          // 0..7
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEMWAIT,
        S_COMMIT,
        S_HALT
    } state_t;

    // Counter reload value; MEMWAIT lasts (WAIT_LOAD + 1) = MEM_WAIT cycles.
    localparam logic [2:0] WAIT_LOAD = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    state_t      state_q,       state_d;
    logic [2:0]  wait_q,        wait_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;

    logic in_commit;
    logic active;

    assign in_commit = (state_q == S_COMMIT);
    assign active    = (state_q == S_FETCH)   || (state_q == S_EXEC) ||
                       (state_q == S_MEMWAIT) || (state_q == S_COMMIT);

    // Write enables are purely combinational from state so the datapath sees
    // them only during the commit cycle.
    assign bus.regWrite   = in_commit & bus.regWriteIn;
    assign bus.memWrite   = in_commit & bus.memWriteIn;
    assign bus.commit     = in_commit;
    assign bus.halted     = (state_q == S_HALT);
    assign bus.instrAddr  = pc_q;
    assign bus.instrCount = instr_count_q;
    assign bus.cycleCount = cycle_count_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        wait_d        = wait_q;
        pc_d          = pc_q;
        instr_count_d = instr_count_q;
        cycle_count_d = cycle_count_q;

        if (active && (cycle_count_q != CNT_MAX)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                end
            end
            // One cycle to cover the instruction BRAM read latency.
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (bus.opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else if (bus.memRead && (MEM_WAIT > 0)) begin
                    wait_d  = WAIT_LOAD;
                    state_d = S_MEMWAIT;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_MEMWAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = S_COMMIT;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_COMMIT: begin
                // Retirement: the only place the PC moves apart from reset.
                pc_d    = bus.nextInstrAddr;
                state_d = S_FETCH;
                if (instr_count_q != CNT_MAX) begin
                    instr_count_d = instr_count_q + 32'd1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and reaches every register here; there
        // is no memory array, so nothing is left out of reset.
        if (rst) begin
            state_q       <= S_IDLE;
            wait_q        <= 3'd0;
            pc_q          <= RESET_PC;
            instr_count_q <= 32'd0;
            cycle_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            pc_q          <= pc_d;
            instr_count_q <= instr_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. Each instruction is described by its
// inputs; the bench model derives the expected per-cycle outputs from the
// instruction length (3, or 3+MEM_WAIT for loads, halt stops after EXEC) and
// saturating counter arithmetic. A single compare process checks all outputs
// mid-cycle; literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int unsigned MW     = 1;
    localparam logic [31:0] RST_PC = 32'd0;
    localparam logic [4:0]  HALT   = 5'b11111;

    logic clk = 1'b0;
    logic rst;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC    (RST_PC),
        .HALT_OPCODE (HALT),
        .MEM_WAIT    (MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model of the architecturally visible outputs for the current cycle.
    logic [31:0] m_pc, m_ic, m_cc;
    logic        m_commit, m_rw, m_mw, m_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // Compare process: outputs sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("instrAddr",  bus.instrAddr,  m_pc);
            check("instrCount", bus.instrCount, m_ic);
            check("cycleCount", bus.cycleCount, m_cc);
            check("commit",     32'(bus.commit),   32'(m_commit));
            check("regWrite",   32'(bus.regWrite), 32'(m_rw));
            check("memWrite",   32'(bus.memWrite), 32'(m_mw));
            check("halted",     32'(bus.halted),   32'(m_halted));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_ic     = 32'd0;
        m_cc     = 32'd0;
        m_commit = 1'b0;
        m_rw     = 1'b0;
        m_mw     = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called in an IDLE cycle; returns in the FETCH cycle.
    task automatic start();
        bus.run = 1'b1;
        step();
        bus.run = 1'b0;
    endtask

    // Called in the FETCH cycle of the instruction; returns in the FETCH
    // cycle of the following one (or in HALT).
    task automatic instr(input logic [4:0] op, input logic mr, input logic rw,
                         input logic mw, input logic [31:0] npc);
        int len;
        bus.opcode        = op;
        bus.memRead       = mr;
        bus.regWriteIn    = rw;
        bus.memWriteIn    = mw;
        bus.nextInstrAddr = npc;
        if (op == HALT) begin
            for (int k = 0; k < 2; k++) begin
                step();
                m_cc = sat_inc(m_cc);
            end
            m_halted = 1'b1;
        end else begin
            len = (mr && MW > 0) ? 3 + int'(MW) : 3;
            for (int k = 0; k < len; k++) begin
                m_commit = (k == len - 1);
                m_rw     = m_commit & rw;
                m_mw     = m_commit & mw;
                step();
                m_cc = sat_inc(m_cc);
            end
            m_commit = 1'b0;
            m_rw     = 1'b0;
            m_mw     = 1'b0;
            m_pc     = npc;
            m_ic     = sat_inc(m_ic);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.run           = 1'b0;
        bus.opcode        = 5'd0;
        bus.memRead       = 1'b0;
        bus.regWriteIn    = 1'b0;
        bus.memWriteIn    = 1'b0;
        bus.nextInstrAddr = 32'd0;
        model_reset();

        // 1: reset for two cycles, then idle with run low.
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;
        idle_cycles(5);
        check("idle_pc", bus.instrAddr, 32'd0);
        check("idle_cc", bus.cycleCount, 32'd0);

        // 2: plain ALU instruction, register write on commit only.
        start();
        instr(5'b00000, 1'b0, 1'b1, 1'b0, 32'd1);
        check("alu_pc", bus.instrAddr,  32'd1);
        check("alu_ic", bus.instrCount, 32'd1);
        check("alu_cc", bus.cycleCount, 32'd3);

        // 3: load with one memory wait cycle, commit in cycle 4.
        instr(5'b00001, 1'b1, 1'b1, 1'b0, 32'd5);
        check("ld_pc", bus.instrAddr,  32'd5);
        check("ld_ic", bus.instrCount, 32'd2);
        check("ld_cc", bus.cycleCount, 32'd7);

        // Store: memory write on commit, no register write.
        instr(5'b00010, 1'b0, 1'b0, 1'b1, 32'd6);
        check("st_pc", bus.instrAddr,  32'd6);
        check("st_cc", bus.cycleCount, 32'd10);

        // 4: halt with regWriteIn set; then run held high for 10 cycles.
        instr(HALT, 1'b0, 1'b1, 1'b0, 32'h40);
        bus.run = 1'b1;
        idle_cycles(10);
        bus.run = 1'b0;
        check("halt_flag", 32'(bus.halted), 32'd1);
        check("halt_pc",   bus.instrAddr,   32'd6);
        check("halt_ic",   bus.instrCount,  32'd3);
        check("halt_cc",   bus.cycleCount,  32'd12);

        // Leave HALT through reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        idle_cycles(2);

        // 5: reset during MEMWAIT of a load that also requests a memory write.
        start();
        bus.opcode        = 5'b00011;
        bus.memRead       = 1'b1;
        bus.regWriteIn    = 1'b1;
        bus.memWriteIn    = 1'b1;
        bus.nextInstrAddr = 32'd9;
        step();                      // EXEC
        m_cc = sat_inc(m_cc);
        step();                      // MEMWAIT
        m_cc = sat_inc(m_cc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        idle_cycles(3);              // counters must stay at 0 while idle
        check("rst_pc", bus.instrAddr,  RST_PC);
        check("rst_ic", bus.instrCount, 32'd0);
        check("rst_cc", bus.cycleCount, 32'd0);

        // 6: preload counters near the top, then run two instructions.
        force dut.instr_count_d = 32'hFFFF_FFFE;
        force dut.cycle_count_d = 32'hFFFF_FFFC;
        step();
        release dut.instr_count_d;
        release dut.cycle_count_d;
        m_ic = 32'hFFFF_FFFE;
        m_cc = 32'hFFFF_FFFC;
        idle_cycles(1);
        start();
        instr(5'b00000, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        instr(5'b00001, 1'b1, 1'b0, 1'b0, 32'd0);
        check("sat_ic", bus.instrCount, 32'hFFFF_FFFF);
        check("sat_cc", bus.cycleCount, 32'hFFFF_FFFF);
        check("wrap_pc", bus.instrAddr, 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
